axi4lite_cmd_manager: RTL and testbench

- AXI4-Lite manager that turns a simple command/response stream into single AXI4-Lite read or write transactions, one outstanding at a time; used by PL-side sequencers to program ADC trigger/config register blocks without the PS.
- Issues AW and W concurrently, accepts them in any order, collects B/R, and returns one response per command; a watchdog converts a hung subordinate into an error response.

---
 rtl/axi4lite_cmd_manager.sv | 231 +++++++++++++++++++++++
 tb/tb_axi4lite_cmd_manager.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_cmd_manager.sv
// AXI4-Lite manager: turns a command/response stream into single AXI4-Lite
// read or write transactions, one outstanding at a time. A watchdog turns a
// hung subordinate into a local error response (rsp_resp = 2'b11). A late B/R
// that arrives after such a timeout is drained silently before the next
// command is accepted.
module axi4lite_cmd_manager #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [2:0]  PROT           = 3'b000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic [31:0] m_axi_lite_awaddr,
    output logic [2:0]  m_axi_lite_awprot,
    output logic        m_axi_lite_awvalid,
    input  logic        m_axi_lite_awready,
    output logic [31:0] m_axi_lite_wdata,
    output logic [3:0]  m_axi_lite_wstrb,
    output logic        m_axi_lite_wvalid,
    input  logic        m_axi_lite_wready,
    input  logic [1:0]  m_axi_lite_bresp,
    input  logic        m_axi_lite_bvalid,
    output logic        m_axi_lite_bready,
    output logic [31:0] m_axi_lite_araddr,
    output logic [2:0]  m_axi_lite_arprot,
    output logic        m_axi_lite_arvalid,
    input  logic        m_axi_lite_arready,
    input  logic [31:0] m_axi_lite_rdata,
    input  logic [1:0]  m_axi_lite_rresp,
    input  logic        m_axi_lite_rvalid,
    output logic        m_axi_lite_rready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    localparam logic [1:0] RESP_TIMEOUT = 2'b11;

    state_t      state_r, state_next_s;
    logic [31:0] addr_r, wdata_r, rsp_rdata_r, wdog_r;
    logic [3:0]  wstrb_r;
    logic [1:0]  rsp_resp_r;
    logic        awvalid_r, wvalid_r, arvalid_r, bready_r, rready_r;
    logic        cmd_ready_r, rsp_valid_r, drain_wr_r, drain_rd_r;

    logic [31:0] addr_s, wdata_s, rsp_rdata_s, wdog_s;
    logic [3:0]  wstrb_s;
    logic [1:0]  rsp_resp_s;
    logic        awvalid_s, wvalid_s, arvalid_s, bready_s, rready_s;
    logic        cmd_ready_s, rsp_valid_s, drain_wr_s, drain_rd_s;

    logic cmd_accept_s, aw_done_s, w_done_s, b_hs_s, r_hs_s, timeout_s;

    assign cmd_accept_s = cmd_valid & cmd_ready_r;
    // A channel counts as done once its valid has dropped or it handshakes now.
    assign aw_done_s    = ~awvalid_r | m_axi_lite_awready;
    assign w_done_s     = ~wvalid_r  | m_axi_lite_wready;
    assign b_hs_s       = m_axi_lite_bvalid & bready_r;
    assign r_hs_s       = m_axi_lite_rvalid & rready_r;
    // >= so an overrun accumulated in WRITE/READ still fires once the
    // response phase is reached, even with the counter saturated.
    assign timeout_s    = (TIMEOUT_CYCLES != 32'd0) && (wdog_r >= TIMEOUT_CYCLES);

    assign cmd_ready          = cmd_ready_r;
    assign rsp_valid          = rsp_valid_r;
    assign rsp_rdata          = rsp_rdata_r;
    assign rsp_resp           = rsp_resp_r;
    assign m_axi_lite_awaddr  = addr_r;
    assign m_axi_lite_awprot  = PROT;
    assign m_axi_lite_awvalid = awvalid_r;
    assign m_axi_lite_wdata   = wdata_r;
    assign m_axi_lite_wstrb   = wstrb_r;
    assign m_axi_lite_wvalid  = wvalid_r;
    assign m_axi_lite_bready  = bready_r;
    assign m_axi_lite_araddr  = addr_r;
    assign m_axi_lite_arprot  = PROT;
    assign m_axi_lite_arvalid = arvalid_r;
    assign m_axi_lite_rready  = rready_r;

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; a B/R handshake takes priority over a same-cycle timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  if (cmd_accept_s) state_next_s = cmd_write ? ST_WRITE : ST_READ;
                      else              state_next_s = ST_IDLE;
            ST_WRITE: if (aw_done_s && w_done_s) state_next_s = ST_WRESP;
                      else                       state_next_s = ST_WRITE;
            ST_WRESP: if (b_hs_s || timeout_s) state_next_s = ST_RSP;
                      else                     state_next_s = ST_WRESP;
            ST_READ:  if (m_axi_lite_arready) state_next_s = ST_RDATA;
                      else                    state_next_s = ST_READ;
            ST_RDATA: if (r_hs_s || timeout_s) state_next_s = ST_RSP;
                      else                     state_next_s = ST_RDATA;
            ST_RSP:   if (rsp_ready) state_next_s = ST_IDLE;
                      else           state_next_s = ST_RSP;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Next values of every registered output, derived from state and next state.
    always_comb begin
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        arvalid_s   = 1'b0;
        rsp_rdata_s = rsp_rdata_r;
        rsp_resp_s  = rsp_resp_r;
        case (state_r)
            ST_IDLE: begin
                awvalid_s = cmd_accept_s & cmd_write;
                wvalid_s  = cmd_accept_s & cmd_write;
                arvalid_s = cmd_accept_s & ~cmd_write;
            end
            ST_WRITE: begin
                awvalid_s = awvalid_r & ~m_axi_lite_awready;
                wvalid_s  = wvalid_r  & ~m_axi_lite_wready;
            end
            ST_READ: begin
                arvalid_s = arvalid_r & ~m_axi_lite_arready;
            end
            ST_WRESP: begin
                if (b_hs_s) begin
                    rsp_rdata_s = 32'd0;
                    rsp_resp_s  = m_axi_lite_bresp;
                end else if (timeout_s) begin
                    rsp_rdata_s = 32'd0;
                    rsp_resp_s  = RESP_TIMEOUT;
                end else begin
                    rsp_rdata_s = rsp_rdata_r;
                    rsp_resp_s  = rsp_resp_r;
                end
            end
            ST_RDATA: begin
                if (r_hs_s) begin
                    rsp_rdata_s = m_axi_lite_rdata;
                    rsp_resp_s  = m_axi_lite_rresp;
                end else if (timeout_s) begin
                    rsp_rdata_s = 32'd0;
                    rsp_resp_s  = RESP_TIMEOUT;
                end else begin
                    rsp_rdata_s = rsp_rdata_r;
                    rsp_resp_s  = rsp_resp_r;
                end
            end
            default: begin
                awvalid_s = 1'b0;
            end
        endcase
        // Drain flags: while set, ready is held and the channel is discarded.
        // Ready is 1 while draining, so bvalid/rvalid alone mark the handshake.
        drain_wr_s  = (drain_wr_r & ~m_axi_lite_bvalid) |
                      ((state_r == ST_WRESP) & ~b_hs_s & timeout_s);
        drain_rd_s  = (drain_rd_r & ~m_axi_lite_rvalid) |
                      ((state_r == ST_RDATA) & ~r_hs_s & timeout_s);
        bready_s    = (state_next_s == ST_WRESP) | drain_wr_s;
        rready_s    = (state_next_s == ST_RDATA) | drain_rd_s;
        cmd_ready_s = (state_next_s == ST_IDLE) & ~drain_wr_s & ~drain_rd_s;
        rsp_valid_s = (state_next_s == ST_RSP);
        addr_s      = cmd_accept_s ? cmd_addr : addr_r;
        wdata_s     = (cmd_accept_s & cmd_write) ? cmd_wdata : wdata_r;
        wstrb_s     = (cmd_accept_s & cmd_write) ? cmd_wstrb : wstrb_r;
        if ((state_r == ST_IDLE) || (state_r == ST_RSP)) begin
            wdog_s = 32'd0;
        end else if (wdog_r == 32'hFFFF_FFFF) begin
            wdog_s = wdog_r;
        end else begin
            wdog_s = wdog_r + 32'd1;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            bready_r    <= 1'b0;
            rready_r    <= 1'b0;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_resp_r  <= 2'b00;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            wstrb_r     <= 4'd0;
            wdog_r      <= 32'd0;
            drain_wr_r  <= 1'b0;
            drain_rd_r  <= 1'b0;
        end else begin
            awvalid_r   <= awvalid_s;
            wvalid_r    <= wvalid_s;
            arvalid_r   <= arvalid_s;
            bready_r    <= bready_s;
            rready_r    <= rready_s;
            cmd_ready_r <= cmd_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_resp_r  <= rsp_resp_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            wstrb_r     <= wstrb_s;
            wdog_r      <= wdog_s;
            drain_wr_r  <= drain_wr_s;
            drain_rd_r  <= drain_rd_s;
        end
    end

endmodule

// File: tb/tb_axi4lite_cmd_manager.sv
// Self-checking bench for axi4lite_cmd_manager: directed subordinate scripts,
// a transaction-level scoreboard checked every cycle, plus literal spot checks.
module tb_axi4lite_cmd_manager;

    localparam int unsigned TMO = 16;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 aclk = ~aclk;

    axi4lite_cmd_manager #(.TIMEOUT_CYCLES(TMO), .PROT(3'b000)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_lite_awaddr(awaddr), .m_axi_lite_awprot(awprot), .m_axi_lite_awvalid(awvalid),
        .m_axi_lite_awready(awready), .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb),
        .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready), .m_axi_lite_bresp(bresp),
        .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready), .m_axi_lite_araddr(araddr),
        .m_axi_lite_arprot(arprot), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
        .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
        .m_axi_lite_rready(rready)
    );

    typedef struct packed { logic [31:0] rdata; logic [1:0] resp; } rsp_t;

    // Scoreboard state, owned by the compare process.
    rsp_t        exp_q[$];
    rsp_t        front;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    bit          m_busy, pend_aw, pend_w, pend_ar;
    int          m_owed_b, m_owed_r, bready_total;
    int          checks_m = 0, fails_m = 0;

    // Owned by the directed sequence.
    logic [31:0] exp_rdata, got_rdata;
    logic [1:0]  exp_resp, got_resp;
    int          checks_d = 0, fails_d = 0;
    int          cyc = 0, acc_cyc, rsp_cyc, b_before;

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_m++;
        if (act !== exp) begin
            fails_m++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_d++;
        if (act !== exp) begin
            fails_d++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, check outputs against the model,
    // then apply the handshakes that will complete at the next rising edge.
    initial forever begin
        @(negedge aclk);
        if (areset) begin
            exp_q.delete();
            m_busy = 1'b0; m_owed_b = 0; m_owed_r = 0;
            pend_aw = 1'b0; pend_w = 1'b0; pend_ar = 1'b0;
        end else begin
            mchk("cmd_ready", 32'(cmd_ready), 32'(!m_busy && m_owed_b == 0 && m_owed_r == 0));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    mchk("spurious_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    front = exp_q[0];
                    mchk("rsp_rdata", rsp_rdata, front.rdata);
                    mchk("rsp_resp", 32'(rsp_resp), 32'(front.resp));
                end
            end
            if (pend_aw) mchk("aw_hold", 32'(awvalid), 32'd1);
            if (pend_w)  mchk("w_hold", 32'(wvalid), 32'd1);
            if (pend_ar) mchk("ar_hold", 32'(arvalid), 32'd1);
            if (awvalid) begin
                mchk("awaddr", awaddr, m_addr);
                mchk("awprot", 32'(awprot), 32'd0);
            end
            if (wvalid) begin
                mchk("wdata", wdata, m_wdata);
                mchk("wstrb", 32'(wstrb), 32'(m_wstrb));
            end
            if (arvalid) begin
                mchk("araddr", araddr, m_addr);
                mchk("arprot", 32'(arprot), 32'd0);
            end
            pend_aw = awvalid & ~awready;
            pend_w  = wvalid & ~wready;
            pend_ar = arvalid & ~arready;
            if (bready) bready_total++;
            if (bvalid && bready) m_owed_b--;
            if (rvalid && rready) m_owed_r--;
            if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                m_busy = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                m_busy = 1'b1;
                exp_q.push_back({exp_rdata, exp_resp});
                m_addr = cmd_addr;
                if (cmd_write) begin
                    m_wdata = cmd_wdata; m_wstrb = cmd_wstrb; m_owed_b++;
                end else begin
                    m_owed_r++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] er, input logic [1:0] ep);
        bit ok = 1'b0;
        exp_rdata = er; exp_resp = ep;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        tick();
        cmd_valid = 1'b0;
        acc_cyc = cyc;
        dchk("cmd_accept", 32'(ok), 32'd1);
    endtask

    task automatic sub_write(input int aw_dly, input int w_dly, input int b_dly,
                             input bit give_b, input logic [1:0] resp);
        bit ok = 1'b0;
        fork
            begin
                for (int n = 0; n < 40 && !awvalid; n++) tick();
                repeat (aw_dly) tick();
                awready = 1'b1; tick(); awready = 1'b0;
            end
            begin
                for (int n = 0; n < 40 && !wvalid; n++) tick();
                repeat (w_dly) tick();
                wready = 1'b1; tick(); wready = 1'b0;
            end
        join
        if (give_b) begin
            repeat (b_dly) tick();
            bresp = resp; bvalid = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge aclk);
                if (bready) begin ok = 1'b1; break; end
            end
            tick();
            bvalid = 1'b0; bresp = 2'b00;
            dchk("b_handshake", 32'(ok), 32'd1);
        end
    endtask

    task automatic sub_read(input int ar_dly, input int r_dly, input logic [31:0] d, input logic [1:0] resp);
        bit ok = 1'b0;
        for (int n = 0; n < 40 && !arvalid; n++) tick();
        repeat (ar_dly) tick();
        arready = 1'b1; tick(); arready = 1'b0;
        repeat (r_dly) tick();
        rdata = d; rresp = resp; rvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (rready) begin ok = 1'b1; break; end
        end
        tick();
        rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
        dchk("r_handshake", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input int budget);
        bit got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (rsp_valid) begin got = 1'b1; break; end
            tick();
        end
        rsp_cyc = cyc; got_rdata = rsp_rdata; got_resp = rsp_resp;
        dchk("rsp_arrives", 32'(got), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1, "bench timed out");
    end

    initial begin
        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0;
        cmd_wdata = 32'd0; cmd_wstrb = 4'd0; rsp_ready = 1'b1;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
        exp_rdata = 32'd0; exp_resp = 2'b00;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;

        // Reset state.
        dchk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        dchk("rst_awvalid", 32'(awvalid), 32'd0);
        dchk("rst_wvalid", 32'(wvalid), 32'd0);
        dchk("rst_arvalid", 32'(arvalid), 32'd0);
        dchk("rst_bready", 32'(bready), 32'd0);
        dchk("rst_rready", 32'(rready), 32'd0);
        dchk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        dchk("rst_rsp_resp", 32'(rsp_resp), 32'd0);
        dchk("rst_awaddr", awaddr, 32'd0);
        tick();

        // T1: write, AW and W accepted in the same cycle.
        b_before = bready_total;
        send_cmd(1'b1, 32'h0000_0104, 32'h0000_0032, 4'hF, 32'd0, 2'b00);
        fork
            sub_write(0, 0, 0, 1'b1, 2'b00);
            wait_rsp(40);
            begin
                dchk("t1_awvalid_n1", 32'(awvalid), 32'd1);
                dchk("t1_wvalid_n1", 32'(wvalid), 32'd1);
                tick();
                dchk("t1_awvalid_n2", 32'(awvalid), 32'd0);
                dchk("t1_wvalid_n2", 32'(wvalid), 32'd0);
            end
        join
        dchk("t1_resp", 32'(got_resp), 32'd0);
        dchk("t1_rdata", got_rdata, 32'd0);
        tick(); tick();
        dchk("t1_bready_pulses", 32'(bready_total - b_before), 32'd1);

        // T2: W accepted three cycles before AW.
        b_before = bready_total;
        send_cmd(1'b1, 32'h0000_0140, 32'hA5A5_0F0F, 4'h5, 32'd0, 2'b00);
        fork
            sub_write(3, 0, 0, 1'b1, 2'b00);
            wait_rsp(40);
            begin
                tick();
                dchk("t2_w_dropped", 32'(wvalid), 32'd0);
                dchk("t2_aw_held", 32'(awvalid), 32'd1);
            end
        join
        dchk("t2_resp", 32'(got_resp), 32'd0);
        tick(); tick();
        dchk("t2_bready_pulses", 32'(bready_total - b_before), 32'd1);

        // T3: read with two wait cycles before R.
        send_cmd(1'b0, 32'h0000_0108, 32'd0, 4'd0, 32'h0000_0004, 2'b00);
        fork
            sub_read(0, 2, 32'h0000_0004, 2'b00);
            wait_rsp(40);
        join
        dchk("t3_rdata", got_rdata, 32'h0000_0004);
        dchk("t3_resp", 32'(got_resp), 32'd0);
        tick(); tick();

        // T4: SLVERR read, response back-pressured for 5 cycles.
        rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h0000_0200, 32'd0, 4'd0, 32'hBAD0_0200, 2'b10);
        fork
            sub_read(0, 0, 32'hBAD0_0200, 2'b10);
            wait_rsp(40);
        join
        for (int i = 0; i < 5; i++) begin
            dchk("t4_hold_valid", 32'(rsp_valid), 32'd1);
            dchk("t4_hold_resp", 32'(rsp_resp), 32'h2);
            dchk("t4_hold_rdata", rsp_rdata, 32'hBAD0_0200);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        dchk("t4_rsp_dropped", 32'(rsp_valid), 32'd0);
        tick();

        // T5: subordinate never answers B; watchdog fires, late B is drained.
        send_cmd(1'b1, 32'h0000_0110, 32'h0000_1234, 4'h3, 32'd0, 2'b11);
        fork
            sub_write(0, 0, 0, 1'b0, 2'b00);
            wait_rsp(60);
        join
        dchk("t5_latency", 32'(rsp_cyc - acc_cyc), 32'd17);
        dchk("t5_resp", 32'(got_resp), 32'h3);
        dchk("t5_rdata", got_rdata, 32'd0);
        tick();
        dchk("t5_drain_blocks_cmd", 32'(cmd_ready), 32'd0);
        dchk("t5_drain_bready", 32'(bready), 32'd1);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        dchk("t5_drain_done_bready", 32'(bready), 32'd0);
        dchk("t5_cmd_ready_back", 32'(cmd_ready), 32'd1);
        dchk("t5_no_second_rsp", 32'(rsp_valid), 32'd0);
        repeat (3) tick();

        // Normal write after the timeout, with SLVERR passed through.
        send_cmd(1'b1, 32'h0000_0120, 32'h0000_00FF, 4'h1, 32'd0, 2'b10);
        fork
            sub_write(1, 2, 1, 1'b1, 2'b10);
            wait_rsp(40);
        join
        dchk("t5b_resp", 32'(got_resp), 32'h2);
        tick(); tick();

        // T6: reset pulse while waiting in WRESP.
        awready = 1'b1; wready = 1'b1;
        send_cmd(1'b1, 32'h0000_0130, 32'h0000_0055, 4'hF, 32'd0, 2'b00);
        tick();
        dchk("t6_in_wresp", 32'(bready), 32'd1);
        areset = 1'b1;
        tick();
        areset = 1'b0; awready = 1'b0; wready = 1'b0;
        dchk("t6_awvalid", 32'(awvalid), 32'd0);
        dchk("t6_wvalid", 32'(wvalid), 32'd0);
        dchk("t6_bready", 32'(bready), 32'd0);
        dchk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (4) tick();
        dchk("t6_no_rsp", 32'(rsp_valid), 32'd0);

        // Recovery read after reset.
        send_cmd(1'b0, 32'h0000_0134, 32'd0, 4'd0, 32'h0000_7777, 2'b01);
        fork
            sub_read(1, 1, 32'h0000_7777, 2'b01);
            wait_rsp(40);
        join
        dchk("t6b_rdata", got_rdata, 32'h0000_7777);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks_m + checks_d, fails_m + fails_d);
        $finish;
    end

endmodule
